// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: geometry defaults, widths, pixel record, address helper.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 120;
  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned COORD_W   = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input int unsigned        width);
    return FB_ADDR_W'(x) + FB_ADDR_W'(y) * FB_ADDR_W'(width);
  endfunction

endpackage

// File: rtl/fb_writer_if.sv
// Pixel-stream input handshake plus framebuffer write port.
// slave = fb_writer side, master = pixel source / framebuffer side.
interface fb_writer_if;
  import fb_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [COORD_W-1:0]   in_x;
  logic [COORD_W-1:0]   in_y;
  logic [COLOR_W-1:0]   in_color;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_wren;
  logic                 fb_ready;

  modport slave  (input  in_valid, in_x, in_y, in_color, fb_ready,
                  output in_ready, fb_addr, fb_data, fb_wren);
  modport master (output in_valid, in_x, in_y, in_color, fb_ready,
                  input  in_ready, fb_addr, fb_data, fb_wren);
endinterface

// File: rtl/fb_writer_pix_fifo.sv
// pix_fifo: synchronous FIFO, power-of-two depth, async active-high reset.
// Pointers carry one extra wrap bit to tell full from empty.
module pix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // Read/write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/fb_writer.sv
// fb_writer: buffers a pixel stream and turns it into framebuffer writes
// (addr = x + y*WIDTH) through a registered output stage with backpressure.
// Optional macro FB_WRITER_COLOR_KEY_EN: pixels of KEY_COLOR are counted
// as written but never drive fb_wren.
module fb_writer
  import fb_pkg::*;
#(
  parameter int unsigned        WIDTH      = FB_WIDTH,
  parameter int unsigned        HEIGHT     = FB_HEIGHT,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [COLOR_W-1:0] KEY_COLOR  = 12'h000
) (
  input  logic                 clk,
  input  logic                 rst,
  fb_writer_if.slave           bus,
  output logic [FB_ADDR_W-1:0] pixel_count,
  output logic                 frame_done,
  output logic                 oor_err
);
`ifdef FB_WRITER_COLOR_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(WIDTH * HEIGHT - 1);

  logic                 init_q;
  logic                 full, empty, push, pop;
  pixel_t               in_pix, head;
  logic [FB_ADDR_W-1:0] addr_q, addr_d, head_addr, cnt_q, cnt_d;
  logic [COLOR_W-1:0]   data_q, data_d;
  logic                 wren_q, wren_d, frame_q, frame_d, oor_q, oor_d;
  logic                 in_range, is_key;

  // in_ready only depends on registered state, so no path from in_valid/fb_ready.
  assign bus.in_ready = init_q & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~empty & (~wren_q | bus.fb_ready);
  assign in_pix       = '{x: bus.in_x, y: bus.in_y, color: bus.in_color};

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(pixel_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (in_pix),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Output stage: retire accepted write, then load the popped pixel.
  always_comb begin
    addr_d    = addr_q;
    data_d    = data_q;
    wren_d    = wren_q;
    cnt_d     = cnt_q;
    frame_d   = 1'b0;
    oor_d     = oor_q;
    in_range  = (32'(head.x) < WIDTH) && (32'(head.y) < HEIGHT);
    is_key    = KEY_EN && (head.color == KEY_COLOR);
    head_addr = pix_addr(head.x, head.y, WIDTH);

    if (wren_q && bus.fb_ready) begin
      wren_d = 1'b0;
      if (addr_q == LAST_ADDR) begin
        cnt_d   = '0;
        frame_d = 1'b1;
      end else begin
        cnt_d = cnt_q + FB_ADDR_W'(1);
      end
    end

    if (pop) begin
      if (!in_range) begin
        oor_d = 1'b1;
      end else if (is_key) begin
        // Keyed pixel retires at pop time; chains onto any write retired above.
        if (head_addr == LAST_ADDR) begin
          cnt_d   = '0;
          frame_d = 1'b1;
        end else begin
          cnt_d = cnt_d + FB_ADDR_W'(1);
        end
      end else begin
        addr_d = head_addr;
        data_d = head.color;
        wren_d = 1'b1;
      end
    end
  end

  // Output/status registers; reset abandons any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      init_q  <= 1'b1;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      oor_q   <= oor_d;
    end
  end

  assign bus.fb_addr = addr_q;
  assign bus.fb_data = data_q;
  assign bus.fb_wren = wren_q;
  assign pixel_count = cnt_q;
  assign frame_done  = frame_q;
  assign oor_err     = oor_q;
endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: directed stimulus pushes expected writes into a queue,
// an independent negedge monitor pops and compares each accepted write.
module tb_fb_writer;
  import fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] pixel_count;
  logic        frame_done, oor_err;

  fb_writer_if bus();

  fb_writer #(
    .WIDTH      (160),
    .HEIGHT     (120),
    .FIFO_DEPTH (4),
    .KEY_COLOR  (12'h000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .pixel_count (pixel_count),
    .frame_done  (frame_done),
    .oor_err     (oor_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] addr;
    logic [11:0] data;
  } exp_t;

  exp_t        expq[$];
  int          vectors = 0;
  int          miss    = 0;
  int          frames  = 0;
  int          writes  = 0;
  logic [14:0] last_wr_addr = '0;
  logic        prev_hold = 1'b0;
  logic [14:0] hold_addr = '0;
  logic [11:0] hold_data = '0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted write against the scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_wren", int'(bus.fb_wren), 1);
        check("hold_addr", int'(bus.fb_addr), int'(hold_addr));
        check("hold_data", int'(bus.fb_data), int'(hold_data));
      end
      if (frame_done) begin
        frames++;
        check("frame_done_addr", int'(last_wr_addr), 19199);
        check("count_at_frame", int'(pixel_count), 0);
      end
      if (bus.fb_wren && bus.fb_ready) begin
        writes++;
        if (expq.size() == 0) begin
          vectors++;
          miss++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                   bus.fb_addr, bus.fb_data);
        end else begin
          e = expq.pop_front();
          check("wr_addr", int'(bus.fb_addr), int'(e.addr));
          check("wr_data", int'(bus.fb_data), int'(e.data));
        end
        last_wr_addr = bus.fb_addr;
      end
      prev_hold = bus.fb_wren && !bus.fb_ready;
      hold_addr = bus.fb_addr;
      hold_data = bus.fb_data;
    end
  end

  function automatic bit is_keyed(input logic [11:0] c);
`ifdef FB_WRITER_COLOR_KEY_EN
    return c == 12'h000;
`else
    return 1'b0 && (c == 12'h000);
`endif
  endfunction

  // Present one pixel until accepted; returns number of cycles taken.
  task automatic send(input int x, input int y, input logic [11:0] c, output int tries);
    bit   acc;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_x     = 8'(x);
    bus.in_y     = 8'(y);
    bus.in_color = c;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tries++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      vectors++;
      miss++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, expected accept", tries);
    end else if (x < 160 && y < 120 && !is_keyed(c)) begin
      e.addr = 15'(x + y * 160);
      e.data = c;
      expq.push_back(e);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    expq.delete();
    cycles(2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, total, k, f0, w0;
    bit acc;
    exp_t e;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_color = '0;
    bus.fb_ready = 1'b1;

    // Reset state
    #22;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_wren", int'(bus.fb_wren), 0);
    check("rst_addr", int'(bus.fb_addr), 0);
    check("rst_data", int'(bus.fb_data), 0);
    check("rst_count", int'(pixel_count), 0);
    check("rst_frame", int'(frame_done), 0);
    check("rst_oor", int'(oor_err), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready_before_edge", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 check("in_ready_after_edge", int'(bus.in_ready), 1);

    // Single pixel, two-edge latency
    send(3, 2, 12'hF00, t);
    bus.in_valid = 1'b0;
    check("lat_edge_n", int'(bus.fb_wren), 0);
    cycles(1);
    check("lat_edge_n1_wren", int'(bus.fb_wren), 1);
    check("lat_edge_n1_addr", int'(bus.fb_addr), 323);
    check("lat_edge_n1_data", int'(bus.fb_data), 12'hF00);
    cycles(1);
    check("single_wren_drop", int'(bus.fb_wren), 0);
    check("single_count", int'(pixel_count), 1);

    // Full raster at one pixel per cycle
    do_reset();
    f0 = frames;
    w0 = writes;
    total = 0;
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 160; x++) begin
        send(x, y, 12'((x * 7 + y * 13) & 12'hFFF), t);
        total += t;
      end
    end
    bus.in_valid = 1'b0;
    wait_drain();
    cycles(3);
    check("raster_cycles", total, 19200);
    check("raster_writes", writes - w0, 19200);
    check("raster_frames", frames - f0, 1);
    check("raster_count", int'(pixel_count), 0);

    // Backpressure: 10 cycles of fb_ready=0
    do_reset();
    bus.fb_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'(k);
      bus.in_y     = 8'd1;
      bus.in_color = 12'(12'h100 + k);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        e.addr = 15'(k + 160);
        e.data = 12'(12'h100 + k);
        expq.push_back(e);
        k++;
      end
    end
    check("stall_accepted", k, 5);
    check("stall_in_ready", int'(bus.in_ready), 0);
    check("stall_wren", int'(bus.fb_wren), 1);
    check("stall_addr", int'(bus.fb_addr), 160);
    bus.fb_ready = 1'b1;
    for (int j = 5; j < 8; j++) send(j, 1, 12'(12'h100 + j), t);
    bus.in_valid = 1'b0;
    wait_drain();
    cycles(2);
    check("stall_count", int'(pixel_count), 8);

    // Out-of-range pixel
    do_reset();
    check("oor_clear", int'(oor_err), 0);
    send(160, 0, 12'hABC, t);
    bus.in_valid = 1'b0;
    cycles(4);
    check("oor_set", int'(oor_err), 1);
    check("oor_count", int'(pixel_count), 0);
    check("oor_wren", int'(bus.fb_wren), 0);
    send(7, 0, 12'h123, t);
    bus.in_valid = 1'b0;
    wait_drain();
    cycles(2);
    check("oor_sticky", int'(oor_err), 1);
    check("oor_after_count", int'(pixel_count), 1);

    // Reset with a write in flight
    do_reset();
    bus.fb_ready = 1'b0;
    send(9, 9, 12'h555, t);
    bus.in_valid = 1'b0;
    cycles(1);
    check("inflight_wren", int'(bus.fb_wren), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    expq.delete();
    #1;
    check("midrst_wren", int'(bus.fb_wren), 0);
    check("midrst_addr", int'(bus.fb_addr), 0);
    check("midrst_data", int'(bus.fb_data), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_count", int'(pixel_count), 0);
    bus.fb_ready = 1'b1;
    cycles(2);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_pre", int'(bus.in_ready), 0);
    @(posedge clk);
    #1 check("midrst_ready_post", int'(bus.in_ready), 1);
    cycles(4);
    check("midrst_fifo_empty", int'(bus.fb_wren), 0);
    check("midrst_no_count", int'(pixel_count), 0);

    // Key colour pixel
    do_reset();
    send(5, 0, 12'h000, t);
    bus.in_valid = 1'b0;
    wait_drain();
    cycles(3);
    check("key_count", int'(pixel_count), 1);
    check("key_wren", int'(bus.fb_wren), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
